// File: rtl/matmul_ctrl_param.sv
// Sequencing controller for the matrix-multiply datapath: operand load gating,
// per-column MAC bursts, column write-back strobes, abort and job completion.
module matmul_ctrl_param #(
  parameter int N_COL = 4,
  parameter int N_MUL = 8,
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1,
  localparam int MUL_W = (N_MUL > 1) ? $clog2(N_MUL) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             xload_done,
  input  logic             aload_done,
  input  logic             abort,
  output logic             input_load_en,
  output logic             ALU_en,
  output logic             acc_clr,
  output logic [MUL_W-1:0] mul_idx,
  output logic [COL_W-1:0] col_idx,
  output logic             col_wr,
  output logic             busy,
  output logic             finish
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [MUL_W-1:0] MUL_LAST = MUL_W'(N_MUL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);

  state_t           state, state_n;
  logic [MUL_W-1:0] mul_n;
  logic [COL_W-1:0] col_n;
  logic             x_flag, a_flag, x_n, a_n;

  always_comb begin
    state_n = state;
    mul_n   = mul_idx;
    col_n   = col_idx;
    x_n     = x_flag;
    a_n     = a_flag;
    case (state)
      IDLE: begin
        mul_n = '0;
        col_n = '0;
        x_n   = 1'b0;
        a_n   = 1'b0;
        if (start_in) state_n = LOAD;
      end
      LOAD: begin
        // Flags plus the live inputs let simultaneous or staggered arrival advance.
        x_n = x_flag | xload_done;
        a_n = a_flag | aload_done;
        if (x_n && a_n) begin
          state_n = MUL;
          x_n     = 1'b0;
          a_n     = 1'b0;
        end
      end
      MUL: begin
        if (mul_idx == MUL_LAST) begin
          state_n = NEXT;
          mul_n   = '0;
        end else begin
          mul_n = mul_idx + MUL_W'(1);
        end
      end
      NEXT: begin
        if (col_idx == COL_LAST) begin
          state_n = DONE;
          col_n   = '0;
        end else begin
          state_n = MUL;
          col_n   = col_idx + COL_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        col_n   = '0;
      end
      default: begin
        state_n = IDLE;
        mul_n   = '0;
        col_n   = '0;
        x_n     = 1'b0;
        a_n     = 1'b0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      mul_n   = '0;
      col_n   = '0;
      x_n     = 1'b0;
      a_n     = 1'b0;
    end
  end

  // Outputs are registered from the next-state decode so they align with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mul_idx       <= '0;
      col_idx       <= '0;
      x_flag        <= 1'b0;
      a_flag        <= 1'b0;
      input_load_en <= 1'b0;
      ALU_en        <= 1'b0;
      acc_clr       <= 1'b0;
      col_wr        <= 1'b0;
      busy          <= 1'b0;
      finish        <= 1'b0;
    end else begin
      state         <= state_n;
      mul_idx       <= mul_n;
      col_idx       <= col_n;
      x_flag        <= x_n;
      a_flag        <= a_n;
      input_load_en <= (state_n == LOAD);
      ALU_en        <= (state_n == MUL);
      acc_clr       <= (state_n == MUL) && (mul_n == '0);
      col_wr        <= (state_n == NEXT);
      busy          <= (state_n != IDLE);
      finish        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// Scoreboard bench for matmul_ctrl_param: three configurations, expected
// event timelines computed arithmetically per job and checked by a monitor.
module tb_matmul_ctrl_param;

  localparam int NONE = 1 << 28;
  localparam int K_LD  = 0;
  localparam int K_MAC = 1;
  localparam int K_WR  = 2;
  localparam int K_FIN = 3;

  function automatic int nc_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 3 : 1;
  endfunction

  function automatic int nm_of(input int g);
    return (g == 0) ? 8 : (g == 1) ? 5 : 1;
  endfunction

  typedef struct {
    int g;
    int kind;
    int col;
    int mul;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic [2:0] start_v, xl_v, al_v, ab_v;
  logic [2:0] ld_v, alu_v, acc_v, wr_v, busy_v, fin_v;
  logic [2:0][7:0] mul_v, col_v;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NC = nc_of(g);
    localparam int NM = nm_of(g);
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    logic [MW-1:0] m_w;
    logic [CW-1:0] c_w;
    matmul_ctrl_param #(.N_COL(NC), .N_MUL(NM)) u_dut (
      .clk(clk), .rst(rst), .start_in(start_v[g]), .xload_done(xl_v[g]),
      .aload_done(al_v[g]), .abort(ab_v[g]), .input_load_en(ld_v[g]),
      .ALU_en(alu_v[g]), .acc_clr(acc_v[g]), .mul_idx(m_w), .col_idx(c_w),
      .col_wr(wr_v[g]), .busy(busy_v[g]), .finish(fin_v[g])
    );
    assign mul_v[g] = 8'(m_w);
    assign col_v[g] = 8'(c_w);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int g, input int k, input int c,
                                  input int m, input int t);
    ev_t e;
    e.g = g; e.kind = k; e.col = c; e.mul = m; e.cyc = t;
    sb.push_back(e);
  endfunction

  // Reference timeline: LOAD until loads complete, then NC columns of NM MACs
  // plus one write-back each, then one finish; nothing after the abort cycle.
  function automatic void push_job(input int g, input int s, input int lmax,
                                   input int ab);
    int nc = nc_of(g);
    int nm = nm_of(g);
    int t_mul = s + lmax + 1;
    for (int c = s + 1; c < t_mul; c++)
      if (c <= ab) push_ev(g, K_LD, 0, 0, c);
    for (int col = 0; col < nc; col++) begin
      for (int m = 0; m < nm; m++) begin
        int t = t_mul + col * (nm + 1) + m;
        if (t <= ab) push_ev(g, K_MAC, col, m, t);
      end
      if (t_mul + col * (nm + 1) + nm <= ab)
        push_ev(g, K_WR, col, 0, t_mul + col * (nm + 1) + nm);
    end
    if (t_mul + nc * (nm + 1) <= ab) push_ev(g, K_FIN, 0, 0, t_mul + nc * (nm + 1));
  endfunction

  task automatic clear_inputs();
    start_v = '0; xl_v = '0; al_v = '0; ab_v = '0;
  endtask

  task automatic run_job(input int g, input int dx, input int da, input bit lvl,
                         input int ab_off, input bit noise, input bit rep,
                         input bit hold);
    int s, lmax, t_mul, t_fin, ab, end_c;
    bit do_hold;
    @(posedge clk); #1;
    s     = cyc;
    lmax  = (dx > da) ? dx : da;
    t_mul = s + lmax + 1;
    t_fin = t_mul + nc_of(g) * (nm_of(g) + 1);
    ab    = (ab_off == NONE) ? NONE : t_mul + ab_off;
    if (ab < s + 1) ab = s + 1;
    if (ab != NONE && ab > t_fin) ab = t_fin;
    do_hold = hold && (ab >= t_fin);
    push_job(g, s, lmax, ab);
    end_c = do_hold ? t_fin : (((ab < t_fin) ? ab : t_fin) + 1);
    for (int c = s; c <= end_c; c++) begin
      clear_inputs();
      start_v[g] = (c == s) || (rep && c == t_mul + 2 && ab >= t_mul + 2) ||
                   (do_hold && c == t_fin);
      xl_v[g] = (lvl ? (c >= s + dx && c < t_mul) : (c == s + dx)) ||
                (noise && (c == s || c == t_mul + 1));
      al_v[g] = (lvl ? (c >= s + da && c < t_mul) : (c == s + da)) ||
                (noise && (c == s || c == t_mul + 1));
      ab_v[g] = (c == ab);
      if (c < end_c) begin
        @(posedge clk); #1;
      end
    end
    if (!do_hold) begin
      @(negedge clk);
      chk("idle_busy", int'(busy_v[g]), 0);
      chk("idle_mul_idx", int'(mul_v[g]), 0);
      chk("idle_col_idx", int'(col_v[g]), 0);
    end
  endtask

  // Monitor: every cycle a DUT shows an event output, pop and compare.
  initial begin
    ev_t e;
    int  mask;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        mask = {28'd0, fin_v[g], wr_v[g], alu_v[g], ld_v[g]};
        if (acc_v[g] && !alu_v[g]) chk("acc_clr_without_alu", 1, 0);
        if (mask != 0) begin
          if (sb.size() == 0) begin
            chk("unexpected_event_mask", mask, 0);
          end else begin
            e = sb.pop_front();
            chk("event_dut", g, e.g);
            chk("event_kind_mask", mask, 1 << e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_busy", int'(busy_v[g]), 1);
            if (e.kind == K_MAC) begin
              chk("mac_mul_idx", int'(mul_v[g]), e.mul);
              chk("mac_col_idx", int'(col_v[g]), e.col);
              chk("mac_acc_clr", int'(acc_v[g]), (e.mul == 0) ? 1 : 0);
            end
            if (e.kind == K_WR) chk("wr_col_idx", int'(col_v[g]), e.col);
          end
        end
      end
    end
  end

  initial begin
    int s;
    rst = 1'b0;
    clear_inputs();
    #3;
    for (int g = 0; g < 3; g++) begin
      chk("reset_outputs", int'({ld_v[g], alu_v[g], acc_v[g], wr_v[g], busy_v[g], fin_v[g]}), 0);
      chk("reset_counters", int'(mul_v[g]) + int'(col_v[g]), 0);
    end
    #9 rst = 1'b1;

    run_job(0, 4, 4, 0, NONE, 0, 0, 0);
    run_job(0, 2, 6, 0, NONE, 0, 0, 0);
    run_job(0, 1, 1, 0, 2 * 9 + 5, 0, 0, 0);
    run_job(0, 5, 3, 0, -2, 0, 0, 0);
    run_job(0, 3, 2, 1, NONE, 1, 1, 1);
    run_job(0, 1, 2, 0, NONE, 0, 0, 0);
    run_job(1, 1, 1, 0, NONE, 0, 0, 0);
    run_job(1, 2, 2, 0, 18, 0, 0, 0);
    run_job(2, 1, 1, 0, NONE, 0, 1, 1);
    run_job(2, 2, 1, 0, NONE, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int g, dx, da, nc, nm, ab_off;
      g  = int'($urandom_range(2, 0));
      dx = int'($urandom_range(6, 1));
      da = int'($urandom_range(6, 1));
      nc = nc_of(g);
      nm = nm_of(g);
      ab_off = NONE;
      if ($urandom_range(2, 0) == 0)
        ab_off = int'($urandom_range(nc * (nm + 1) + 6, 0)) - 6;
      run_job(g, dx, da, 1'($urandom_range(1, 0)), ab_off, 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), (i != 23) && ($urandom_range(3, 0) == 0));
    end

    // Asynchronous reset mid-MUL on the default configuration.
    @(posedge clk); #1;
    clear_inputs();
    s = cyc;
    push_job(0, s, 1, s + 4);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    xl_v[0] = 1'b1;
    al_v[0] = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({ld_v[0], alu_v[0], acc_v[0], wr_v[0], busy_v[0], fin_v[0]}), 0);
    chk("async_reset_mul_idx", int'(mul_v[0]), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("after_reset_busy", int'(busy_v[0]), 0);
    chk("after_reset_alu", int'(alu_v[0]), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
